nbody_force_engine: RTL



---
 rtl/nbody_force_engine.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/nbody_force_engine.sv
// rtl/nbody_force_engine.sv - pairwise fixed-point gravity force accumulator with iterative sqrt/divide
// Optional NBODY_FORCE_SAT_EN: saturating per-axis accumulation plus sticky out_sat flag.
module nbody_force_engine #(
   parameter int POS_W  = 16,
   parameter int MASS_W = 16,
   parameter int G_FIX  = 1,
   parameter int SHIFT  = 16,
   parameter int SOFT   = 1,
   parameter int Q_W    = 32,
   parameter int ACC_W  = 48
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [POS_W-1:0] in_xi,
   input  logic signed [POS_W-1:0] in_yi,
   input  logic signed [POS_W-1:0] in_xj,
   input  logic signed [POS_W-1:0] in_yj,
   input  logic [MASS_W-1:0]       in_mass_j,
   input  logic                    in_skip,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] out_fx,
   output logic signed [ACC_W-1:0] out_fy,
   output logic [15:0]             out_count,
   output logic                    busy
`ifdef NBODY_FORCE_SAT_EN
   ,
   output logic                    out_sat
`endif
);

   localparam int D_W    = POS_W + 1;
   localparam int R2_W   = 2 * POS_W + 3;
   localparam int RT_W   = POS_W + 2;
   localparam int RAD_W  = 2 * RT_W;
   localparam int REM_W  = RT_W + 3;
   localparam int DEN_W  = R2_W + RT_W;
   localparam int NUM_W  = MASS_W + 16 + SHIFT;
   localparam int DREM_W = DEN_W + 1;
   localparam int PROD_W = Q_W + 1 + D_W;
   localparam int SUM_W  = ((ACC_W > PROD_W) ? ACC_W : PROD_W) + 1;
   localparam int CNT_W  = $clog2(((NUM_W > RT_W) ? NUM_W : RT_W) + 1);

   localparam logic [15:0]    G16   = 16'(G_FIX);
   localparam logic [Q_W-1:0] Q_MAX = '1;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_DELTA = 3'd1;
   localparam logic [2:0] S_SQRT  = 3'd2;
   localparam logic [2:0] S_CUBE  = 3'd3;
   localparam logic [2:0] S_DIV   = 3'd4;
   localparam logic [2:0] S_FORCE = 3'd5;
   localparam logic [2:0] S_ACCUM = 3'd6;
   localparam logic [2:0] S_OUT   = 3'd7;

   logic [2:0]               r_state;
   logic signed [POS_W-1:0]  r_xi, r_yi, r_xj, r_yj;
   logic [MASS_W-1:0]        r_mass;
   logic                     r_skip, r_last;
   logic signed [D_W-1:0]    r_dx, r_dy;
   logic [R2_W-1:0]          r_r2;
   logic [RAD_W-1:0]         r_rad;
   logic [REM_W-1:0]         r_rem;
   logic [RT_W-1:0]          r_root;
   logic [CNT_W-1:0]         r_cnt;
   logic [DEN_W-1:0]         r_den;
   logic [NUM_W-1:0]         r_num;
   logic [DREM_W-1:0]        r_drem;
   logic [NUM_W-1:0]         r_quo;
   logic signed [PROD_W-1:0] r_cfx, r_cfy;
   logic signed [ACC_W-1:0]  r_acc_x, r_acc_y;
   logic [15:0]              r_count;
   logic                     r_sat;

   logic signed [D_W-1:0]    w_dx, w_dy;
   logic signed [2*D_W-1:0]  w_dx2, w_dy2;
   logic [R2_W-1:0]          w_r2;
   logic [REM_W-1:0]         w_rem_sh, w_trial;
   logic                     w_sq_ge;
   logic [DREM_W-1:0]        w_drem_sh;
   logic                     w_dv_ge;
   logic [NUM_W-1:0]         w_num;
   logic [Q_W-1:0]           w_q;
   logic signed [SUM_W-1:0]  w_sum_x, w_sum_y;
   logic signed [ACC_W-1:0]  w_nx, w_ny;
   logic                     w_ovf;
   logic                     w_unused;

   assign w_dx  = {r_xj[POS_W-1], r_xj} - {r_xi[POS_W-1], r_xi};
   assign w_dy  = {r_yj[POS_W-1], r_yj} - {r_yi[POS_W-1], r_yi};
   assign w_dx2 = w_dx * w_dx;
   assign w_dy2 = w_dy * w_dy;
   assign w_r2  = {1'b0, w_dx2} + {1'b0, w_dy2} + R2_W'(SOFT);

   // Restoring sqrt: bring down two radicand bits per step, trial = 4*root + 1.
   assign w_rem_sh = {r_rem[REM_W-3:0], r_rad[RAD_W-1 -: 2]};
   assign w_trial  = {1'b0, r_root, 2'b01};
   assign w_sq_ge  = (w_rem_sh >= w_trial);

   assign w_drem_sh = {r_drem[DREM_W-2:0], r_num[NUM_W-1]};
   assign w_dv_ge   = (w_drem_sh >= {1'b0, r_den});
   assign w_num     = (NUM_W'(G16) * NUM_W'(r_mass)) << SHIFT;
   assign w_q       = (r_quo > NUM_W'(Q_MAX)) ? Q_MAX : Q_W'(r_quo);

   assign w_sum_x = SUM_W'(r_acc_x) + SUM_W'(r_cfx);
   assign w_sum_y = SUM_W'(r_acc_y) + SUM_W'(r_cfy);

`ifdef NBODY_FORCE_SAT_EN
   localparam logic signed [SUM_W-1:0] ACC_MAX = {{(SUM_W-ACC_W+1){1'b0}}, {(ACC_W-1){1'b1}}};
   localparam logic signed [SUM_W-1:0] ACC_MIN = {{(SUM_W-ACC_W+1){1'b1}}, {(ACC_W-1){1'b0}}};
   logic w_hi_x, w_lo_x, w_hi_y, w_lo_y;
   assign w_hi_x = (w_sum_x > ACC_MAX);
   assign w_lo_x = (w_sum_x < ACC_MIN);
   assign w_hi_y = (w_sum_y > ACC_MAX);
   assign w_lo_y = (w_sum_y < ACC_MIN);
   assign w_nx   = w_hi_x ? ACC_MAX[ACC_W-1:0] : (w_lo_x ? ACC_MIN[ACC_W-1:0] : w_sum_x[ACC_W-1:0]);
   assign w_ny   = w_hi_y ? ACC_MAX[ACC_W-1:0] : (w_lo_y ? ACC_MIN[ACC_W-1:0] : w_sum_y[ACC_W-1:0]);
   assign w_ovf  = w_hi_x | w_lo_x | w_hi_y | w_lo_y;
   assign w_unused = ^{r_rem[REM_W-1 -: 2], r_drem[DREM_W-1]};
   assign out_sat  = r_sat;
`else
   assign w_nx   = w_sum_x[ACC_W-1:0];
   assign w_ny   = w_sum_y[ACC_W-1:0];
   assign w_ovf  = 1'b0;
   assign w_unused = ^{r_rem[REM_W-1 -: 2], r_drem[DREM_W-1], r_sat,
                       w_sum_x[SUM_W-1:ACC_W], w_sum_y[SUM_W-1:ACC_W]};
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_xi    <= '0;
         r_yi    <= '0;
         r_xj    <= '0;
         r_yj    <= '0;
         r_mass  <= '0;
         r_skip  <= 1'b0;
         r_last  <= 1'b0;
         r_dx    <= '0;
         r_dy    <= '0;
         r_r2    <= '0;
         r_rad   <= '0;
         r_rem   <= '0;
         r_root  <= '0;
         r_cnt   <= '0;
         r_den   <= '0;
         r_num   <= '0;
         r_drem  <= '0;
         r_quo   <= '0;
         r_cfx   <= '0;
         r_cfy   <= '0;
         r_acc_x <= '0;
         r_acc_y <= '0;
         r_count <= '0;
         r_sat   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_xi    <= in_xi;
                  r_yi    <= in_yi;
                  r_xj    <= in_xj;
                  r_yj    <= in_yj;
                  r_mass  <= in_mass_j;
                  r_skip  <= in_skip;
                  r_last  <= in_last;
                  r_state <= S_DELTA;
               end
            end
            S_DELTA: begin
               r_dx   <= w_dx;
               r_dy   <= w_dy;
               r_r2   <= w_r2;
               r_rad  <= {{(RAD_W-R2_W){1'b0}}, w_r2};
               r_rem  <= '0;
               r_root <= '0;
               r_cnt  <= '0;
               if (r_skip || (w_r2 == '0)) begin
                  r_cfx   <= '0;
                  r_cfy   <= '0;
                  r_state <= S_ACCUM;
               end else begin
                  r_state <= S_SQRT;
               end
            end
            S_SQRT: begin
               r_rad  <= r_rad << 2;
               r_rem  <= w_sq_ge ? (w_rem_sh - w_trial) : w_rem_sh;
               r_root <= {r_root[RT_W-2:0], w_sq_ge};
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(RT_W - 1)) r_state <= S_CUBE;
            end
            S_CUBE: begin
               r_den   <= DEN_W'(r_r2) * DEN_W'(r_root);
               r_num   <= w_num;
               r_drem  <= '0;
               r_quo   <= '0;
               r_cnt   <= '0;
               r_state <= S_DIV;
            end
            S_DIV: begin
               r_drem <= w_dv_ge ? (w_drem_sh - {1'b0, r_den}) : w_drem_sh;
               r_num  <= r_num << 1;
               r_quo  <= {r_quo[NUM_W-2:0], w_dv_ge};
               r_cnt  <= r_cnt + 1'b1;
               if (r_cnt == CNT_W'(NUM_W - 1)) r_state <= S_FORCE;
            end
            S_FORCE: begin
               r_cfx   <= $signed({1'b0, w_q}) * r_dx;
               r_cfy   <= $signed({1'b0, w_q}) * r_dy;
               r_state <= S_ACCUM;
            end
            S_ACCUM: begin
               r_acc_x <= w_nx;
               r_acc_y <= w_ny;
               r_count <= r_count + 16'd1;
               r_sat   <= r_sat | w_ovf;
               r_state <= r_last ? S_OUT : S_IDLE;
            end
            S_OUT: begin
               if (out_ready) begin
                  r_acc_x <= '0;
                  r_acc_y <= '0;
                  r_count <= '0;
                  r_sat   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = reset_n && (r_state == S_IDLE);
   assign busy      = (r_state != S_IDLE);
   assign out_valid = (r_state == S_OUT);
   assign out_fx    = r_acc_x;
   assign out_fy    = r_acc_y;
   assign out_count = r_count;

endmodule
